// File: rtl/online_div_pkg.sv
// Shared online-divider definitions: signed-digit encodings, word fill states
// and the registered stage-1 command bundle of the digit history bank.
package online_div_pkg;

  localparam logic [1:0] DIGIT_POS  = 2'b10;
  localparam logic [1:0] DIGIT_NEG  = 2'b01;
  localparam logic [1:0] DIGIT_ZERO = 2'b00;

  typedef enum logic [1:0] {
    WORD_EMPTY,
    WORD_FILLING,
    WORD_FULL
  } word_state_e;

  typedef struct packed {
    logic       en;
    logic [1:0] digit;
    logic       refresh;
    logic       commit;
  } stage_cmd_t;

  // The redundant {1,1} pair carries no value and is folded onto zero
  function automatic logic [1:0] canon_digit(input logic [1:0] d);
    return (d == 2'b11) ? DIGIT_ZERO : d;
  endfunction

endpackage

// File: rtl/digit_history_bank_if.sv
// Digit/command/read bus of the digit history bank; the master drives digits,
// commands and read requests, the slave returns read data and word status.
interface digit_history_bank_if #(
  parameter int unsigned UNROLLING  = 64,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned SHIFT_W    = 11
) ();
  localparam int unsigned CNT_W = $clog2(UNROLLING) + 1;

  logic                  enable;
  logic [1:0]            d_in;
  logic                  refresh;
  logic                  commit;
  logic [SHIFT_W-1:0]    shift_cnt;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [UNROLLING-1:0]  d_plus_rd;
  logic [UNROLLING-1:0]  d_minus_rd;
  logic                  rd_valid;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [CNT_W-1:0]      digit_cnt;
  logic                  overflow;

  modport master (
    output enable, d_in, refresh, commit, shift_cnt, rd_en, rd_addr,
    input  d_plus_rd, d_minus_rd, rd_valid, wr_ptr, digit_cnt, overflow
  );

  modport slave (
    input  enable, d_in, refresh, commit, shift_cnt, rd_en, rd_addr,
    output d_plus_rd, d_minus_rd, rd_valid, wr_ptr, digit_cnt, overflow
  );
endinterface

// File: rtl/single_clk_ram_param.sv
// Single-clock RAM with one write port and one registered read-first read port.
// Reset clears only the read register; the array keeps its contents.
module single_clk_ram_param #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking update of mem makes a same-address read return the old word
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/digit_history_bank.sv
// Quotient-digit history store: gathers signed digits into plus/minus words,
// aligns and commits them into a dual-bank RAM behind a self-advancing pointer.
module digit_history_bank
  import online_div_pkg::*;
#(
  parameter int unsigned UNROLLING   = 64,
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned SHIFT_W     = 11,
  parameter bit          AUTO_COMMIT = 1'b1
) (
  input logic                 clk,
  input logic                 asyn_reset,
  digit_history_bank_if.slave bus
);
  localparam int unsigned      CNT_W    = $clog2(UNROLLING) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(UNROLLING);

  stage_cmd_t            s1_cmd_q;
  logic [SHIFT_W-1:0]    s1_shift_q;

  logic [UNROLLING-1:0]  plus_q,  plus_d;
  logic [UNROLLING-1:0]  minus_q, minus_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                  overflow_q, overflow_d;
  logic                  rd_valid_q;

  word_state_e           word_state_c;
  logic                  wr_en_c;
  logic                  ram_we_c;
  logic [UNROLLING-1:0]  wr_plus_c;
  logic [UNROLLING-1:0]  wr_minus_c;
  logic [UNROLLING-1:0]  rd_plus;
  logic [UNROLLING-1:0]  rd_minus;

  // Stage 1: digits and commands registered together so their order is kept
  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      s1_cmd_q   <= '0;
      s1_shift_q <= '0;
    end else begin
      s1_cmd_q   <= '{en:      bus.enable,
                      digit:   canon_digit(bus.d_in),
                      refresh: bus.refresh,
                      commit:  bus.commit};
      s1_shift_q <= bus.shift_cnt;
    end
  end

  always_comb begin
    word_state_c = WORD_FILLING;
    if (cnt_q == '0) begin
      word_state_c = WORD_EMPTY;
    end else if (cnt_q == CNT_FULL) begin
      word_state_c = WORD_FULL;
    end
  end

  // Left alignment; shifting by the word width or more leaves nothing
  always_comb begin
    wr_plus_c  = '0;
    wr_minus_c = '0;
    if (32'(s1_shift_q) < UNROLLING) begin
      wr_plus_c  = plus_q  << s1_shift_q;
      wr_minus_c = minus_q << s1_shift_q;
    end
  end

  // Stage 2: commit writes the old word first, then clear, then accept digit
  always_comb begin
    plus_d     = plus_q;
    minus_d    = minus_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    wr_en_c    = 1'b0;

    if (s1_cmd_q.commit || (AUTO_COMMIT && (word_state_c == WORD_FULL))) begin
      wr_en_c  = 1'b1;
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end

    if (wr_en_c || s1_cmd_q.refresh) begin
      plus_d  = '0;
      minus_d = '0;
      cnt_d   = '0;
    end

    if (s1_cmd_q.en) begin
      if (cnt_d != CNT_FULL) begin
        plus_d  = {plus_d[UNROLLING-2:0],  (s1_cmd_q.digit == DIGIT_POS)};
        minus_d = {minus_d[UNROLLING-2:0], (s1_cmd_q.digit == DIGIT_NEG)};
        cnt_d   = cnt_d + CNT_W'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      plus_q     <= '0;
      minus_q    <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      plus_q     <= plus_d;
      minus_q    <= minus_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
      rd_valid_q <= bus.rd_en;
    end
  end

  // A command still in stage 1 when reset hits must not reach the RAM
  assign ram_we_c = wr_en_c & ~asyn_reset;

  single_clk_ram_param #(
    .WIDTH      (UNROLLING),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram_plus (
    .clk   (clk),
    .rst   (asyn_reset),
    .we    (ram_we_c),
    .waddr (wr_ptr_q),
    .wdata (wr_plus_c),
    .re    (bus.rd_en),
    .raddr (bus.rd_addr),
    .rdata (rd_plus)
  );

  single_clk_ram_param #(
    .WIDTH      (UNROLLING),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram_minus (
    .clk   (clk),
    .rst   (asyn_reset),
    .we    (ram_we_c),
    .waddr (wr_ptr_q),
    .wdata (wr_minus_c),
    .re    (bus.rd_en),
    .raddr (bus.rd_addr),
    .rdata (rd_minus)
  );

  assign bus.d_plus_rd  = rd_plus;
  assign bus.d_minus_rd = rd_minus;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.wr_ptr     = wr_ptr_q;
  assign bus.digit_cnt  = cnt_q;
  assign bus.overflow   = overflow_q;

endmodule
